// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE   = 4'd0,
        CL_ITYPE   = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_CBZ     = 4'd4,
        CL_CBNZ    = 4'd5,
        CL_B       = 4'd6,
        CL_BCOND   = 4'd7,
        CL_BL      = 4'd8,
        CL_MOVZ    = 4'd9,
        CL_MOVK    = 4'd10,
        CL_ILLEGAL = 4'd11
    } inst_class_t;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    // Branch type handed to the PCSrc logic
    localparam logic [2:0] BR_NONE  = 3'b000;
    localparam logic [2:0] BR_CBZ   = 3'b001;
    localparam logic [2:0] BR_CBNZ  = 3'b010;
    localparam logic [2:0] BR_B     = 3'b011;
    localparam logic [2:0] BR_BCOND = 3'b100;
    localparam logic [2:0] BR_BL    = 3'b101;

    // Write-back source
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_MOVK = 2'b11;

    // 11-bit opcodes (inst[31:21]); the masks mark which bits are significant
    localparam logic [10:0] OP_ADD   = 11'h458;
    localparam logic [10:0] OP_ADDS  = 11'h558;
    localparam logic [10:0] OP_SUB   = 11'h658;
    localparam logic [10:0] OP_SUBS  = 11'h758;
    localparam logic [10:0] OP_AND   = 11'h450;
    localparam logic [10:0] OP_ANDS  = 11'h750;
    localparam logic [10:0] OP_ORR   = 11'h550;
    localparam logic [10:0] OP_EOR   = 11'h650;
    localparam logic [10:0] OP_LSL   = 11'h69B;
    localparam logic [10:0] OP_LSR   = 11'h69A;
    localparam logic [10:0] OP_LDUR  = 11'h7C2;
    localparam logic [10:0] OP_STUR  = 11'h7C0;

    localparam logic [10:0] MASK_I   = 11'h7FE;
    localparam logic [10:0] OP_ADDI  = 11'h488;
    localparam logic [10:0] OP_ADDIS = 11'h588;
    localparam logic [10:0] OP_SUBI  = 11'h688;
    localparam logic [10:0] OP_SUBIS = 11'h788;
    localparam logic [10:0] OP_ANDI  = 11'h490;
    localparam logic [10:0] OP_ANDIS = 11'h790;
    localparam logic [10:0] OP_ORRI  = 11'h590;
    localparam logic [10:0] OP_EORI  = 11'h690;

    localparam logic [10:0] MASK_CB  = 11'h7F8;
    localparam logic [10:0] OP_CBZ   = 11'h5A0;
    localparam logic [10:0] OP_CBNZ  = 11'h5A8;
    localparam logic [10:0] OP_BCOND = 11'h2A0;

    localparam logic [10:0] MASK_B   = 11'h7E0;
    localparam logic [10:0] OP_B     = 11'h0A0;
    localparam logic [10:0] OP_BL    = 11'h4A0;

    localparam logic [10:0] MASK_MOV = 11'h7FC;
    localparam logic [10:0] OP_MOVZ  = 11'h694;
    localparam logic [10:0] OP_MOVK  = 11'h794;

    // True when the significant bits of op equal the pattern
    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] care);
        return (op & care) == val;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_inst_classifier.sv
// Maps the 11-bit LEGv8 opcode field to an instruction class plus a flag-setting bit.
// Latency: purely combinational.
// Backpressure: none; output follows the opcode.
module multicycle_ctrl_inst_classifier
    import multicycle_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output inst_class_t cls,
    output logic        set_flags
);

    // Priority-free decode: the opcode patterns are mutually exclusive
    always_comb begin
        cls       = CL_ILLEGAL;
        set_flags = 1'b0;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND ||
            opcode == OP_ANDS || opcode == OP_ORR || opcode == OP_EOR ||
            opcode == OP_LSL || opcode == OP_LSR) begin
            cls = CL_RTYPE;
        end else if (opcode == OP_ADDS || opcode == OP_SUBS) begin
            cls       = CL_RTYPE;
            set_flags = 1'b1;
        end else if (op_match(opcode, OP_ADDIS, MASK_I) ||
                     op_match(opcode, OP_SUBIS, MASK_I)) begin
            cls       = CL_ITYPE;
            set_flags = 1'b1;
        end else if (op_match(opcode, OP_ADDI, MASK_I) || op_match(opcode, OP_SUBI, MASK_I) ||
                     op_match(opcode, OP_ANDI, MASK_I) || op_match(opcode, OP_ANDIS, MASK_I) ||
                     op_match(opcode, OP_ORRI, MASK_I) || op_match(opcode, OP_EORI, MASK_I)) begin
            cls = CL_ITYPE;
        end else if (opcode == OP_LDUR) begin
            cls = CL_LOAD;
        end else if (opcode == OP_STUR) begin
            cls = CL_STORE;
        end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
            cls = CL_CBZ;
        end else if (op_match(opcode, OP_CBNZ, MASK_CB)) begin
            cls = CL_CBNZ;
        end else if (op_match(opcode, OP_BCOND, MASK_CB)) begin
            cls = CL_BCOND;
        end else if (op_match(opcode, OP_B, MASK_B)) begin
            cls = CL_B;
        end else if (op_match(opcode, OP_BL, MASK_B)) begin
            cls = CL_BL;
        end else if (op_match(opcode, OP_MOVZ, MASK_MOV)) begin
            cls = CL_MOVZ;
        end else if (op_match(opcode, OP_MOVK, MASK_MOV)) begin
            cls = CL_MOVK;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control sequencer stepping LEGv8 instructions through FETCH/DECODE/EXEC/MEM/WB.
// Latency: branch 3, R/I/MOV 4, STUR 4 (+MEM wait), LDUR 5 (+MEM wait) cycles from FETCH.
// Backpressure: waits in FETCH for inst_valid and in MEM for mem_ack (bounded by MEM_TIMEOUT).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic             mem_ack,
    output logic             RegWrite,
    output logic             Reg2Loc,
    output logic             WRegLoc,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc,
    output logic [2:0]       BranchOp,
    output logic             SregUp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic             ir_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT) + 1;

    state_t      state, state_nx;
    inst_class_t cls_d, cls_q;
    logic        setf_d, setf_q;
    logic [TW-1:0] tcnt;
    logic        mem_last;
    logic        unused_inst_bits;

    // Only the opcode field matters to control; operand fields belong to the datapath
    assign unused_inst_bits = ^inst[20:0];

    multicycle_ctrl_inst_classifier u_inst_classifier (
        .opcode    (inst[31:21]),
        .cls       (cls_d),
        .set_flags (setf_d)
    );

    // Final permitted MEM cycle: no ack here means the access has timed out
    assign mem_last = (tcnt == TW'(MEM_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (inst_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = (cls_q == CL_ILLEGAL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    CL_B, CL_BCOND, CL_CBZ, CL_CBNZ: state_nx = S_FETCH;
                    CL_LOAD, CL_STORE:               state_nx = S_MEM;
                    default:                         state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack)       state_nx = (cls_q == CL_LOAD) ? S_WB : S_FETCH;
                else if (mem_last) state_nx = S_HALT;
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Class is captured together with the IR so no output ever sees inst combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q  <= CL_ILLEGAL;
            setf_q <= 1'b0;
            tcnt   <= '0;
        end else begin
            if (state == S_FETCH && inst_valid) begin
                cls_q  <= cls_d;
                setf_q <= setf_d;
            end
            tcnt <= (state == S_MEM && state_nx == S_MEM) ? tcnt + TW'(1) : '0;
        end
    end

    // Sticky error flags and retired-instruction counter (every pc_we is a retire)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal     <= 1'b0;
            mem_err     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (state == S_DECODE && cls_q == CL_ILLEGAL) illegal <= 1'b1;
            if (state == S_MEM && !mem_ack && mem_last)   mem_err <= 1'b1;
            if (pc_we) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // Control outputs from registered state and class
    always_comb begin
        RegWrite = 1'b0;
        Reg2Loc  = 1'b0;
        WRegLoc  = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b0;
        BranchOp = BR_NONE;
        SregUp   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = WB_ALU;
        pc_we    = 1'b0;
        ir_we    = (state == S_FETCH) && inst_valid && !rst;
        busy     = (state != S_FETCH) && (state != S_HALT);
        halted   = (state == S_HALT);

        if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB})
            Reg2Loc = cls_q inside {CL_STORE, CL_CBZ, CL_CBNZ, CL_MOVK};

        if (state inside {S_EXEC, S_MEM, S_WB}) begin
            case (cls_q)
                CL_RTYPE:          ALUOp = ALU_RTYPE;
                CL_ITYPE,
                CL_MOVZ, CL_MOVK:  begin ALUOp = ALU_ITYPE; ALUSrc = 1'b1; end
                CL_LOAD, CL_STORE: begin ALUOp = ALU_ADD;   ALUSrc = 1'b1; end
                CL_CBZ:            begin ALUOp = ALU_PASSB; BranchOp = BR_CBZ;  end
                CL_CBNZ:           begin ALUOp = ALU_PASSB; BranchOp = BR_CBNZ; end
                CL_B:              BranchOp = BR_B;
                CL_BCOND:          BranchOp = BR_BCOND;
                CL_BL:             BranchOp = BR_BL;
                default:           ALUOp = ALU_ADD;
            endcase
        end

        case (state)
            S_EXEC: begin
                SregUp = setf_q;
                pc_we  = cls_q inside {CL_B, CL_BCOND, CL_CBZ, CL_CBNZ};
            end
            S_MEM: begin
                MemRead  = (cls_q == CL_LOAD);
                MemWrite = (cls_q == CL_STORE);
                pc_we    = mem_ack && (cls_q == CL_STORE);
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_we    = 1'b1;
                WRegLoc  = (cls_q == CL_BL);
                case (cls_q)
                    CL_LOAD: MemtoReg = WB_MEM;
                    CL_BL:   MemtoReg = WB_PC;
                    CL_MOVK: MemtoReg = WB_MOVK;
                    default: MemtoReg = WB_ALU;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Latency: cycle-by-cycle expectations per instruction class.
// Backpressure: exercises inst_valid gating, delayed mem_ack and MEM timeout.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    localparam logic [31:0] I_ADD  = 32'h8B030041;
    localparam logic [31:0] I_ADDS = 32'hAB030041;
    localparam logic [31:0] I_LDUR = 32'hF8408041;
    localparam logic [31:0] I_STUR = 32'hF8008041;
    localparam logic [31:0] I_B    = 32'h14000001;
    localparam logic [31:0] I_BL   = 32'h94000001;
    localparam logic [31:0] I_CBZ  = 32'hB4000041;
    localparam logic [31:0] I_MOVK = 32'hF2800001;

    // Control vector layout: RegWrite Reg2Loc WRegLoc ALUOp[2] ALUSrc BranchOp[3]
    //                        SregUp MemRead MemWrite MemtoReg[2] ir_we pc_we
    localparam logic [15:0] C_IDLE = 16'b0_0_0_00_0_000_0_0_0_00_0_0;
    localparam logic [15:0] C_IRWE = 16'b0_0_0_00_0_000_0_0_0_00_1_0;

    logic clk, rst, inst_valid, mem_ack;
    logic [31:0] inst;
    logic RegWrite, Reg2Loc, WRegLoc, ALUSrc, SregUp, MemRead, MemWrite;
    logic ir_we, pc_we, busy, halted, illegal, mem_err;
    logic [1:0] ALUOp, MemtoReg;
    logic [2:0] BranchOp;
    logic [CNT_W-1:0] retired_cnt;
    logic [15:0] ctrl;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .mem_ack(mem_ack),
        .RegWrite(RegWrite), .Reg2Loc(Reg2Loc), .WRegLoc(WRegLoc), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .BranchOp(BranchOp), .SregUp(SregUp), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ir_we(ir_we), .pc_we(pc_we),
        .busy(busy), .halted(halted), .illegal(illegal), .mem_err(mem_err),
        .retired_cnt(retired_cnt)
    );

    assign ctrl = {RegWrite, Reg2Loc, WRegLoc, ALUOp, ALUSrc, BranchOp,
                   SregUp, MemRead, MemWrite, MemtoReg, ir_we, pc_we};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst = I_ADD; inst_valid = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_IDLE) begin
            errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE);
        end
        checks++;
        if ({busy, halted, illegal, mem_err} !== 4'b0000 || retired_cnt !== '0) begin
            errors++;
            $display("FAIL reset_status: got b/h/i/e=%b cnt=%0d want 0000 cnt=0",
                     {busy, halted, illegal, mem_err}, retired_cnt);
        end
        inst_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Four-cycle instructions (R/I/MOV/BL): FETCH, DECODE, EXEC, WB
    task automatic test_four_cycle(input string nm, input logic [31:0] word,
                                   input logic [15:0] e_dec, input logic [15:0] e_exe,
                                   input logic [15:0] e_wb, input logic [CNT_W-1:0] ret);
        logic [15:0] exp [5];
        exp[0] = C_IRWE; exp[1] = e_dec; exp[2] = e_exe; exp[3] = e_wb; exp[4] = C_IDLE;
        inst = word; inst_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) inst_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (ctrl !== exp[c]) begin
                errors++; $display("FAIL %s_c%0d: got %b want %b", nm, c, ctrl, exp[c]);
            end
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL %s_busy: got %b want 1", nm, busy);
                end
            end
            tick();
        end
        checks++;
        if (retired_cnt !== ret) begin
            errors++; $display("FAIL %s_retired: got %0d want %0d", nm, retired_cnt, ret);
        end
    endtask

    task automatic test_load();
        logic [15:0] exp [8];
        exp[0] = C_IRWE;
        exp[1] = C_IDLE;
        exp[2] = 16'b0_0_0_00_1_000_0_0_0_00_0_0;
        exp[3] = 16'b0_0_0_00_1_000_0_1_0_00_0_0;
        exp[4] = exp[3];
        exp[5] = exp[3];
        exp[6] = 16'b1_0_0_00_1_000_0_0_0_01_0_1;
        exp[7] = C_IDLE;
        inst = I_LDUR; inst_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            inst_valid = (c == 0);
            mem_ack    = (c == 1) || (c == 5);   // DECODE pulse must be ignored
            @(negedge clk);
            checks++;
            if (ctrl !== exp[c]) begin
                errors++; $display("FAIL ldur_c%0d: got %b want %b", c, ctrl, exp[c]);
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (retired_cnt !== 3) begin
            errors++; $display("FAIL ldur_retired: got %0d want 3", retired_cnt);
        end
    endtask

    task automatic test_store_ack();
        logic [15:0] exp [5];
        exp[0] = C_IRWE;
        exp[1] = 16'b0_1_0_00_0_000_0_0_0_00_0_0;
        exp[2] = 16'b0_1_0_00_1_000_0_0_0_00_0_0;
        exp[3] = 16'b0_1_0_00_1_000_0_0_1_00_0_1;
        exp[4] = C_IDLE;
        inst = I_STUR;
        for (int c = 0; c < 5; c++) begin
            inst_valid = (c == 0);
            mem_ack    = (c == 3);
            @(negedge clk);
            checks++;
            if (ctrl !== exp[c]) begin
                errors++; $display("FAIL stur_c%0d: got %b want %b", c, ctrl, exp[c]);
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (retired_cnt !== 4) begin
            errors++; $display("FAIL stur_retired: got %0d want 4", retired_cnt);
        end
    endtask

    // B immediately followed by CBZ (back to back through FETCH)
    task automatic test_branch_back_to_back();
        logic [15:0] exp [7];
        logic [31:0] words [7];
        exp[0] = C_IRWE; exp[1] = C_IDLE;
        exp[2] = 16'b0_0_0_00_0_011_0_0_0_00_0_1;
        exp[3] = C_IRWE;
        exp[4] = 16'b0_1_0_00_0_000_0_0_0_00_0_0;
        exp[5] = 16'b0_1_0_01_0_001_0_0_0_00_0_1;
        exp[6] = C_IDLE;
        words[0] = I_B; words[1] = I_B; words[2] = I_B;
        words[3] = I_CBZ; words[4] = I_CBZ; words[5] = I_CBZ; words[6] = I_CBZ;
        for (int c = 0; c < 7; c++) begin
            inst = words[c];
            inst_valid = (c == 0) || (c == 3);
            @(negedge clk);
            checks++;
            if (ctrl !== exp[c]) begin
                errors++; $display("FAIL branch_c%0d: got %b want %b", c, ctrl, exp[c]);
            end
            if (c == 3) begin
                checks++;
                if (retired_cnt !== 5) begin
                    errors++; $display("FAIL b_retired: got %0d want 5", retired_cnt);
                end
            end
            tick();
        end
        checks++;
        if (retired_cnt !== 6) begin
            errors++; $display("FAIL cbz_retired: got %0d want 6", retired_cnt);
        end
    endtask

    task automatic test_reset_mid_mem();
        inst = I_LDUR;
        for (int c = 0; c < 3; c++) begin
            inst_valid = (c == 0);
            tick();
        end
        @(negedge clk);
        checks++;
        if (MemRead !== 1'b1) begin
            errors++; $display("FAIL rst_mem_pre: MemRead got %b want 1", MemRead);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctrl: got %b busy=%b want %b busy=0", ctrl, busy, C_IDLE);
        end
        checks++;
        if (retired_cnt !== '0 || illegal !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_status: cnt=%0d ill=%b err=%b want 0 0 0", retired_cnt, illegal, mem_err);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        test_four_cycle("add_after_rst", I_ADD, C_IDLE,
                        16'b0_0_0_10_0_000_0_0_0_00_0_0,
                        16'b1_0_0_10_0_000_0_0_0_00_0_1, 1);
    endtask

    task automatic test_mem_timeout();
        inst = I_STUR;
        for (int c = 0; c < 3; c++) begin
            inst_valid = (c == 0);
            tick();
        end
        for (int m = 0; m < 16; m++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== 16'b0_1_0_00_1_000_0_0_1_00_0_0 || halted !== 1'b0) begin
                errors++; $display("FAIL timeout_mem%0d: got %b halted=%b", m, ctrl, halted);
            end
            tick();
        end
        mem_ack = 1'b1;   // late ack after HALT must change nothing
        @(negedge clk);
        checks++;
        if (ctrl !== C_IDLE || {busy, halted, illegal, mem_err} !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_halt: ctrl=%b b/h/i/e=%b want %b 0101",
                     ctrl, {busy, halted, illegal, mem_err}, C_IDLE);
        end
        checks++;
        if (retired_cnt !== 1) begin
            errors++; $display("FAIL timeout_retired: got %0d want 1", retired_cnt);
        end
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || pc_we !== 1'b0) begin
            errors++; $display("FAIL timeout_stuck: halted=%b pc_we=%b want 1 0", halted, pc_we);
        end
        tick();
    endtask

    task automatic test_illegal();
        rst = 1'b1;
        #1;
        checks++;
        if (mem_err !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL illegal_pre_rst: err=%b halted=%b want 0 0", mem_err, halted);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        inst = 32'h00000000; inst_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_IRWE) begin
            errors++; $display("FAIL illegal_fetch: got %b want %b", ctrl, C_IRWE);
        end
        tick(); tick();
        for (int c = 0; c < 4; c++) begin
            inst_valid = (c % 2 == 0);
            @(negedge clk);
            checks++;
            if (ctrl !== C_IDLE || halted !== 1'b1 || illegal !== 1'b1 || retired_cnt !== '0) begin
                errors++;
                $display("FAIL illegal_halt%0d: ctrl=%b halted=%b illegal=%b cnt=%0d want %b 1 1 0",
                         c, ctrl, halted, illegal, retired_cnt, C_IDLE);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_four_cycle("add", I_ADD, C_IDLE,
                        16'b0_0_0_10_0_000_0_0_0_00_0_0,
                        16'b1_0_0_10_0_000_0_0_0_00_0_1, 1);
        test_four_cycle("adds", I_ADDS, C_IDLE,
                        16'b0_0_0_10_0_000_1_0_0_00_0_0,
                        16'b1_0_0_10_0_000_0_0_0_00_0_1, 2);
        test_load();
        test_store_ack();
        test_branch_back_to_back();
        test_four_cycle("bl", I_BL, C_IDLE,
                        16'b0_0_0_00_0_101_0_0_0_00_0_0,
                        16'b1_0_1_00_0_101_0_0_0_10_0_1, 7);
        test_four_cycle("movk", I_MOVK,
                        16'b0_1_0_00_0_000_0_0_0_00_0_0,
                        16'b0_1_0_11_1_000_0_0_0_00_0_0,
                        16'b1_1_0_11_1_000_0_0_0_11_0_1, 8);
        test_reset_mid_mem();
        test_mem_timeout();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
